// File: rtl/fir_pkg.sv
// Shared constants and types for the time-multiplexed symmetric FIR controller.
package fir_pkg;

  localparam int DEF_IDATA_WIDTH = 12;
  localparam int DEF_PDATA_WIDTH = 13;
  localparam int DEF_COEFF_WIDTH = 12;
  localparam int DEF_FIR_TAP     = 8;
  localparam int DEF_FIR_TAPHALF = 4;
  localparam int DEF_OUT_WIDTH   = 27;

  localparam int DEF_COF_INIT0 = 41;
  localparam int DEF_COF_INIT1 = 132;
  localparam int DEF_COF_INIT2 = 341;
  localparam int DEF_COF_INIT3 = 510;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Selects one of the four symmetric tap pairs / coefficients.
  typedef logic [1:0] coef_idx_t;

endpackage

// File: rtl/fir_preadd_mult.sv
// Shared datapath: adds two mirrored delay-line taps and multiplies the sum by
// one coefficient, with the product captured in a register.
module fir_preadd_mult #(
  parameter int PDATA_WIDTH = 13,
  parameter int COEFF_WIDTH = 12
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      en,
  input  logic signed [PDATA_WIDTH-1:0]             tap_a,
  input  logic signed [PDATA_WIDTH-1:0]             tap_b,
  input  logic signed [COEFF_WIDTH-1:0]             coef,
  output logic signed [PDATA_WIDTH+COEFF_WIDTH-1:0] prod
);

  localparam int PROD_WIDTH = PDATA_WIDTH + COEFF_WIDTH;

  logic signed [PDATA_WIDTH-1:0] pre;
  logic signed [PROD_WIDTH-1:0]  pre_ext;
  logic signed [PROD_WIDTH-1:0]  coef_ext;
  logic signed [PROD_WIDTH-1:0]  prod_full;

  // Taps hold sign-extended samples, so their sum always fits the tap width.
  assign pre       = tap_a + tap_b;
  assign pre_ext   = {{(PROD_WIDTH-PDATA_WIDTH){pre[PDATA_WIDTH-1]}}, pre};
  assign coef_ext  = {{(PROD_WIDTH-COEFF_WIDTH){coef[COEFF_WIDTH-1]}}, coef};
  assign prod_full = pre_ext * coef_ext;

  // Capture the product only while the controller is stepping through taps.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
    end else if (en) begin
      prod <= prod_full;
    end
  end

endmodule

// File: rtl/fir_serial_ctrl.sv
// 8-tap symmetric FIR controller: one pre-adder/multiplier shared across the
// four tap pairs, sample delay line, programmable coefficient bank, and
// valid/ready handshakes on both the sample and result sides.
module fir_serial_ctrl
  import fir_pkg::*;
#(
  parameter int IDATA_WIDTH = DEF_IDATA_WIDTH,
  parameter int PDATA_WIDTH = DEF_PDATA_WIDTH,
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int FIR_TAP     = DEF_FIR_TAP,
  parameter int FIR_TAPHALF = DEF_FIR_TAPHALF,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter logic signed [COEFF_WIDTH-1:0] COF_INIT0 = COEFF_WIDTH'(DEF_COF_INIT0),
  parameter logic signed [COEFF_WIDTH-1:0] COF_INIT1 = COEFF_WIDTH'(DEF_COF_INIT1),
  parameter logic signed [COEFF_WIDTH-1:0] COF_INIT2 = COEFF_WIDTH'(DEF_COF_INIT2),
  parameter logic signed [COEFF_WIDTH-1:0] COF_INIT3 = COEFF_WIDTH'(DEF_COF_INIT3)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [IDATA_WIDTH-1:0] fir_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   fir_out,
  input  logic                          cfg_we,
  input  logic [1:0]                    cfg_addr,
  input  logic signed [COEFF_WIDTH-1:0] cfg_wdata,
  output logic                          cfg_err,
  output logic                          busy
);

  localparam int        PROD_WIDTH = PDATA_WIDTH + COEFF_WIDTH;
  localparam int        TAP_IDX_W  = $clog2(FIR_TAP);
  localparam coef_idx_t LAST_IDX   = coef_idx_t'(FIR_TAPHALF - 1);

  state_t                        state;
  coef_idx_t                     idx;
  logic signed [PDATA_WIDTH-1:0] dline [FIR_TAP];
  logic signed [COEFF_WIDTH-1:0] coef  [FIR_TAPHALF];
  logic signed [OUT_WIDTH-1:0]   acc;
  logic signed [PROD_WIDTH-1:0]  prod;
  logic signed [OUT_WIDTH-1:0]   prod_ext;
  logic signed [OUT_WIDTH-1:0]   acc_next;
  logic signed [PDATA_WIDTH-1:0] sample_ext;
  logic [TAP_IDX_W-1:0]          idx_lo;
  logic [TAP_IDX_W-1:0]          idx_hi;
  logic                          cfg_ok;

  assign sample_ext = {{(PDATA_WIDTH-IDATA_WIDTH){fir_in[IDATA_WIDTH-1]}}, fir_in};
  assign prod_ext   = {{(OUT_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
  assign acc_next   = acc + prod_ext;
  assign idx_lo     = TAP_IDX_W'(idx);
  assign idx_hi     = TAP_IDX_W'(FIR_TAP - 1) - idx_lo;

  // A coefficient write may land only while idle and not racing a sample accept.
  assign cfg_ok = (state == IDLE) && !in_valid;

  fir_preadd_mult #(
    .PDATA_WIDTH (PDATA_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH)
  ) u_preadd_mult (
    .clk   (clk),
    .rst   (rst),
    .en    (state == MAC),
    .tap_a (dline[idx_lo]),
    .tap_b (dline[idx_hi]),
    .coef  (coef[idx]),
    .prod  (prod)
  );

  // Coefficient bank: accepts writes only when safe, otherwise flags the rejection for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      coef[0] <= COF_INIT0;
      coef[1] <= COF_INIT1;
      coef[2] <= COF_INIT2;
      coef[3] <= COF_INIT3;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) begin
        coef[cfg_addr] <= cfg_wdata;
      end
    end
  end

  // Sequencer: accept a sample, run one MAC step per tap pair (the accumulator trails the product register by a cycle), flush the last product, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      fir_out   <= '0;
      busy      <= 1'b0;
      for (int k = 0; k < FIR_TAP; k++) begin
        dline[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = FIR_TAP - 1; k > 0; k--) begin
              dline[k] <= dline[k-1];
            end
            dline[0] <= sample_ext;
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MAC;
          end
        end
        MAC: begin
          if (idx != '0) begin
            acc <= acc_next;
          end
          if (idx == LAST_IDX) begin
            state <= FLUSH;
          end else begin
            idx <= idx + coef_idx_t'(1);
          end
        end
        FLUSH: begin
          acc       <= acc_next;
          fir_out   <= acc_next;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Self-checking bench for fir_serial_ctrl: table-driven impulse/step/full-scale
// vectors, hand-written backpressure, config and reset sequences, and random
// samples compared against a direct-convolution reference model.
module tb_fir_serial_ctrl;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [11:0]  fir_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [26:0]  fir_out;
  logic                cfg_we;
  logic [1:0]          cfg_addr;
  logic signed [11:0]  cfg_wdata;
  logic                cfg_err;
  logic                busy;

  int vec_count  = 0;
  int miss_count = 0;
  int hist [8];
  int cm   [4];
  int pending_exp;

  typedef struct {
    string name;
    int    sample;
    bit    has_exp;
    int    expected;
  } vec_t;

  vec_t tbl [$];

  // Free-running clock.
  always #5 clk = ~clk;

  fir_serial_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fir_in    (fir_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fir_out   (fir_out),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  // Hard stop in case the design wedges somewhere a bounded wait does not cover.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vec_count++;
    if (act != exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) hist[k] = 0;
    cm[0] = 41; cm[1] = 132; cm[2] = 341; cm[3] = 510;
  endfunction

  // Direct-form convolution with the mirrored coefficient set.
  function automatic int model_push(input int x);
    int s = 0;
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    for (int k = 0; k < 8; k++) s += hist[k] * cm[(k < 4) ? k : 7 - k];
    return s;
  endfunction

  function automatic void add_vec(input string name, input int sample, input bit has_exp, input int expected);
    vec_t v;
    v.name = name; v.sample = sample; v.has_exp = has_exp; v.expected = expected;
    tbl.push_back(v);
  endfunction

  // Offer a sample and return at the falling edge just after it was accepted.
  task automatic start_sample(input int x);
    int n = 0;
    @(negedge clk);
    fir_in   = 12'(x);
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid    = 1'b0;
    pending_exp = model_push(x);
  endtask

  // Wait for the result; lat0 is how many falling edges already passed since accept.
  task automatic finish_sample(input string name, input int lat0);
    int lat = lat0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_latency"}, lat, 5);
    checkOutput(name, int'(fir_out), pending_exp);
  endtask

  task automatic applyStimulus(input int x, input string name);
    start_sample(x);
    finish_sample(name, 0);
  endtask

  task automatic cfg_write(input int addr, input int data);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 2'(addr);
    cfg_wdata = 12'(data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  initial begin
    int seen;
    int exp_bp;
    int addr;
    int data;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0;
    fir_in = '0; cfg_addr = '0; cfg_wdata = '0;
    model_reset();

    // Impulse: coefficients appear in mirrored order.
    add_vec("impulse", 1, 1, 41);
    add_vec("impulse", 0, 1, 132);
    add_vec("impulse", 0, 1, 341);
    add_vec("impulse", 0, 1, 510);
    add_vec("impulse", 0, 1, 510);
    add_vec("impulse", 0, 1, 341);
    add_vec("impulse", 0, 1, 132);
    add_vec("impulse", 0, 1, 41);
    add_vec("impulse", 0, 1, 0);
    // Step of 100 from an empty delay line.
    add_vec("step", 100, 1, 4100);
    add_vec("step", 100, 1, 17300);
    add_vec("step", 100, 1, 51400);
    add_vec("step", 100, 1, 102400);
    add_vec("step", 100, 1, 153400);
    add_vec("step", 100, 1, 187500);
    add_vec("step", 100, 1, 200700);
    add_vec("step", 100, 1, 204800);
    add_vec("step", 100, 1, 204800);
    // Negative full scale.
    for (int i = 0; i < 7; i++) add_vec("negfs", -2048, 0, 0);
    add_vec("negfs", -2048, 1, -4194304);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_fir_out", int'(fir_out), 0);
    checkOutput("rst_cfg_err", int'(cfg_err), 0);
    checkOutput("rst_busy", int'(busy), 0);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].sample, tbl[i].name);
      if (tbl[i].has_exp) checkOutput({tbl[i].name, "_const"}, int'(fir_out), tbl[i].expected);
    end

    // Backpressure: result held while the next sample waits outside.
    start_sample(300);
    out_ready = 1'b0;
    finish_sample("bp_first", 0);
    exp_bp   = pending_exp;
    fir_in   = -12'sd555;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", int'(out_valid), 1);
      checkOutput("bp_fir_out", int'(fir_out), exp_bp);
      checkOutput("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", int'(out_valid), 0);
    checkOutput("bp_release_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid    = 1'b0;
    pending_exp = model_push(-555);
    finish_sample("bp_held", 0);

    // Coefficient write while idle takes effect on the next sample.
    for (int i = 0; i < 8; i++) applyStimulus(0, "zero_fill");
    cfg_write(0, -100);
    checkOutput("cfg_err_idle", int'(cfg_err), 0);
    cm[0] = -100;
    applyStimulus(1, "cfg_impulse");
    checkOutput("cfg_impulse_const", int'(fir_out), -100);

    // Coefficient write during MAC is rejected with a single-cycle error.
    start_sample(7);
    cfg_write(1, 777);
    checkOutput("cfg_err_mac", int'(cfg_err), 1);
    @(negedge clk);
    checkOutput("cfg_err_pulse", int'(cfg_err), 0);
    finish_sample("cfg_rejected", 3);
    applyStimulus(0, "post_reject");
    applyStimulus(0, "post_reject");

    // Reset at the third edge after accept discards the result.
    start_sample(1000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_in_ready", int'(in_ready), 1);
    checkOutput("midrst_busy", int'(busy), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checkOutput("midrst_no_out", seen, 0);
    model_reset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].sample, "post_rst_impulse");
      checkOutput("post_rst_const", int'(fir_out), tbl[i].expected);
    end

    // Random samples with occasional coefficient reprogramming.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        addr = int'($urandom_range(0, 3));
        data = int'($urandom_range(0, 4095)) - 2048;
        cfg_write(addr, data);
        checkOutput("rand_cfg_err", int'(cfg_err), 0);
        cm[addr] = data;
      end
      applyStimulus(int'($urandom_range(0, 4095)) - 2048, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
